// File: rtl/decode_stage.sv
// RV32I decode stage: DEPTH-entry instruction queue feeding a registered decode bundle.
// Optional DECODE_STAGE_ILLEGAL_EN adds an illegal-instruction output.
package decode_pkg;
  // Register ops use {f7[5],f3} directly as the ALU code.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_LUI = 4'b1010;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [2:0]  f3;
    logic        alu_pc;
    logic        alu_imm;
    logic        alu_we;
    logic        j;
    logic        br;
    logic        ld;
    logic        st;
`ifdef DECODE_STAGE_ILLEGAL_EN
    logic        illegal;
`endif
  } id_ex_t;
endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [31:0]     imm,
  output logic [3:0]      alu_op,
  output logic [2:0]      f3,
  output logic            alu_pc,
  output logic            alu_imm,
  output logic            alu_we,
  output logic            j,
  output logic            br,
  output logic            ld,
  output logic            st,
`ifdef DECODE_STAGE_ILLEGAL_EN
  output logic            illegal,
`endif
  output logic [CNT_W-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]     qi [DEPTH];
  logic [PC_W-1:0] qp [DEPTH];
  logic [PW-1:0]   wp, rp;
  logic            push, pop;
  logic [31:0]     inst;
  id_ex_t          d, b;

  assign in_ready = (count != CNT_W'(DEPTH));
  assign push = in_valid && in_ready && !flush;
  assign pop  = (count != '0) && (!out_valid || out_ready) && !flush;
  assign inst = qi[rp];

  always_ff @(posedge clk) begin
    if (push) begin
      qi[wp] <= in_inst;
      qp[wp] <= in_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  logic [6:0] opc;
  logic is_op, is_opi, is_ld, is_st;
  logic is_br, is_jal, is_jalr, is_lui, is_aui;

  assign opc     = inst[6:0];
  assign is_op   = (opc == 7'b0110011);
  assign is_opi  = (opc == 7'b0010011);
  assign is_ld   = (opc == 7'b0000011);
  assign is_st   = (opc == 7'b0100011);
  assign is_br   = (opc == 7'b1100011);
  assign is_jal  = (opc == 7'b1101111);
  assign is_jalr = (opc == 7'b1100111);
  assign is_lui  = (opc == 7'b0110111);
  assign is_aui  = (opc == 7'b0010111);

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};

`ifdef DECODE_STAGE_ILLEGAL_EN
  logic [6:0] f7;
  logic       ill;
  assign f7  = inst[31:25];
  assign ill = (inst[1:0] != 2'b11)
    || !(is_op || is_opi || is_ld || is_st || is_br
         || is_jal || is_jalr || is_lui || is_aui)
    || (is_op && f7 != 7'b0000000 && f7 != 7'b0100000);
`endif

  always_comb begin
    d     = '0;
    d.rd  = inst[11:7];
    d.rs1 = inst[19:15];
    d.rs2 = inst[24:20];
    d.f3  = inst[14:12];
    unique case (1'b1)
      is_op: begin
        d.alu_we = 1'b1;
        d.alu_op = {inst[30], inst[14:12]};
      end
      is_opi: begin
        d.alu_imm = 1'b1;
        d.alu_we  = 1'b1;
        d.imm     = imm_i;
        // Only SRAI distinguishes itself through f7[5].
        d.alu_op  = {(inst[14:12] == 3'b101) & inst[30], inst[14:12]};
      end
      is_ld: begin
        d.ld      = 1'b1;
        d.alu_imm = 1'b1;
        d.alu_op  = ALU_ADD;
        d.imm     = imm_i;
      end
      is_st: begin
        d.st      = 1'b1;
        d.alu_imm = 1'b1;
        d.alu_op  = ALU_ADD;
        d.imm     = imm_s;
      end
      is_br: begin
        d.br      = 1'b1;
        d.alu_pc  = 1'b1;
        d.alu_imm = 1'b1;
        d.alu_op  = ALU_ADD;
        d.imm     = imm_b;
      end
      is_jal: begin
        d.j       = 1'b1;
        d.alu_pc  = 1'b1;
        d.alu_imm = 1'b1;
        d.alu_op  = ALU_ADD;
        d.imm     = imm_j;
      end
      is_jalr: begin
        d.j       = 1'b1;
        d.alu_imm = 1'b1;
        d.alu_op  = ALU_ADD;
        d.imm     = imm_i;
      end
      is_lui: begin
        d.alu_imm = 1'b1;
        d.alu_we  = 1'b1;
        d.alu_op  = ALU_LUI;
        d.imm     = imm_u;
      end
      is_aui: begin
        d.alu_pc  = 1'b1;
        d.alu_imm = 1'b1;
        d.alu_we  = 1'b1;
        d.alu_op  = ALU_ADD;
        d.imm     = imm_u;
      end
      default: ;
    endcase
`ifdef DECODE_STAGE_ILLEGAL_EN
    if (ill) begin
      d.imm     = '0;
      d.alu_op  = '0;
      d.alu_pc  = 1'b0;
      d.alu_imm = 1'b0;
      d.alu_we  = 1'b0;
      d.j       = 1'b0;
      d.br      = 1'b0;
      d.ld      = 1'b0;
      d.st      = 1'b0;
      d.illegal = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      b         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_pc    <= qp[rp];
      b         <= d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign rd      = b.rd;
  assign rs1     = b.rs1;
  assign rs2     = b.rs2;
  assign imm     = b.imm;
  assign alu_op  = b.alu_op;
  assign f3      = b.f3;
  assign alu_pc  = b.alu_pc;
  assign alu_imm = b.alu_imm;
  assign alu_we  = b.alu_we;
  assign j       = b.j;
  assign br      = b.br;
  assign ld      = b.ld;
  assign st      = b.st;
`ifdef DECODE_STAGE_ILLEGAL_EN
  assign illegal = b.illegal;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: latency, decode, backpressure/wrap, flush,
// async reset and unlisted-opcode handling.
module tb_decode_stage;
  import decode_pkg::*;

  localparam int DEPTH = 2;
  localparam int PC_W  = 32;
  localparam int CNT_W = 2;

  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, imm;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [4:0] rd, rs1, rs2;
  logic [3:0] alu_op;
  logic [2:0] f3;
  logic alu_pc, alu_imm, alu_we, j, br, ld, st;
  logic [CNT_W-1:0] count;
`ifdef DECODE_STAGE_ILLEGAL_EN
  logic illegal;
`endif
  logic [6:0] fl;

  assign fl = {alu_pc, alu_imm, alu_we, j, br, ld, st};

  decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .alu_op(alu_op), .f3(f3),
    .alu_pc(alu_pc), .alu_imm(alu_imm), .alu_we(alu_we),
    .j(j), .br(br), .ld(ld), .st(st),
`ifdef DECODE_STAGE_ILLEGAL_EN
    .illegal(illegal),
`endif
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [31:0] t_inst [5] = '{32'h0de08113, 32'hf8209e23,
    32'hffdff0ef, 32'hfe208ce3, 32'hdbeef0b7};
  logic [31:0] t_imm [5] = '{32'h000000de, 32'hffffff9c,
    32'hfffffffc, 32'hfffffff8, 32'hdbeef000};
  logic [6:0] t_fl [5] = '{7'b0110000, 7'b0100001,
    7'b1101000, 7'b1100100, 7'b0110000};
  logic [3:0] t_op [5] = '{ALU_ADD, ALU_ADD, ALU_ADD,
    ALU_ADD, ALU_LUI};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p);
    in_valid = 1'b1;
    in_inst  = i;
    in_pc    = p;
  endtask

  task automatic fill3(input logic [31:0] base);
    for (int i = 0; i < 3; i++) begin
      drive({12'(i + 1), 5'd0, 3'd0, 5'(i + 1), 7'h13},
            base + 32'(4 * i));
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_inst = '0; in_pc = '0; out_ready = 1'b0;
    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_imm", imm, 0);
    chk("rst_flags", fl, 0);
    chk("rst_rd", rd, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);

    // single ADD: two-cycle latency
    drive(32'h00008133, 32'h100);
    tick();
    in_valid = 1'b0;
    chk("lat_n1_valid", out_valid, 1'b0);
    chk("lat_n1_count", count, 1);
    tick();
    chk("add_valid", out_valid, 1'b1);
    chk("add_pc", out_pc, 32'h100);
    chk("add_rd", rd, 2);
    chk("add_rs1", rs1, 1);
    chk("add_rs2", rs2, 0);
    chk("add_op", alu_op, ALU_ADD);
    chk("add_flags", fl, 7'b0010000);
    chk("add_f3", f3, 0);
`ifdef DECODE_STAGE_ILLEGAL_EN
    chk("add_illegal", illegal, 1'b0);
`endif
    out_ready = 1'b1;
    tick();
    chk("add_drain", out_valid, 1'b0);

    // back-to-back stream, one bundle per cycle
    for (int i = 0; i < 7; i++) begin
      if (i < 5) drive(t_inst[i], 32'h200 + 32'(4 * i));
      else in_valid = 1'b0;
      tick();
      if (i == 0) chk("b2b_first_idle", out_valid, 1'b0);
      if (i >= 1 && i <= 5) begin
        chk($sformatf("b2b%0d_valid", i - 1), out_valid, 1'b1);
        chk($sformatf("b2b%0d_pc", i - 1), out_pc,
            32'h200 + 32'(4 * (i - 1)));
        chk($sformatf("b2b%0d_imm", i - 1), imm, t_imm[i - 1]);
        chk($sformatf("b2b%0d_flags", i - 1), fl, t_fl[i - 1]);
        chk($sformatf("b2b%0d_op", i - 1), alu_op, t_op[i - 1]);
      end
      if (i >= 1 && i <= 4) chk("b2b_count", count, 1);
      if (i == 6) chk("b2b_end", out_valid, 1'b0);
    end

    // backpressure: fill to DEPTH, hold, then drain with wrap
    out_ready = 1'b0;
    fill3(32'h300);
    chk("full_count", count, DEPTH);
    chk("full_in_ready", in_ready, 1'b0);
    chk("hold_pc", out_pc, 32'h300);
    drive(32'h00400213, 32'h30c);
    tick();
    in_valid = 1'b0;
    chk("full_no_push", count, DEPTH);
    chk("hold_valid", out_valid, 1'b1);
    chk("hold_pc2", out_pc, 32'h300);
    chk("hold_imm", imm, 1);
    out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      chk($sformatf("drain%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("drain%0d_pc", i), out_pc, 32'h300 + 32'(4 * i));
      chk($sformatf("drain%0d_imm", i), imm, 32'(i + 1));
      chk($sformatf("drain%0d_count", i), count, 32'(2 - i));
    end
    tick();
    chk("drain_end", out_valid, 1'b0);

    // flush on a full queue with a simultaneous push attempt
    out_ready = 1'b0;
    fill3(32'h400);
    chk("pre_flush_count", count, DEPTH);
    flush = 1'b1;
    drive(32'h00500293, 32'h4f0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_quiet", out_valid, 1'b0);
    end
    drive(32'h00600313, 32'h500);
    tick();
    in_valid = 1'b0;
    tick();
    chk("post_flush_valid", out_valid, 1'b1);
    chk("post_flush_pc", out_pc, 32'h500);
    chk("post_flush_imm", imm, 6);
    tick();

    // unlisted opcode
    drive(32'h0000007f, 32'h600);
    tick();
    in_valid = 1'b0;
    tick();
    chk("unl_valid", out_valid, 1'b1);
    chk("unl_pc", out_pc, 32'h600);
    chk("unl_flags", fl, 0);
    chk("unl_imm", imm, 0);
`ifdef DECODE_STAGE_ILLEGAL_EN
    chk("unl_illegal", illegal, 1'b1);
`endif
    tick();

    // asynchronous reset between edges
    out_ready = 1'b0;
    drive(32'h00700393, 32'h700);
    tick();
    drive(32'h00800413, 32'h704);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1'b1);
    chk("pre_rst_count", count, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_count", count, 0);
    chk("arst_pc", out_pc, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("arst_no_emit", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
